// File: rtl/ysyx_23060184_clint.sv
// AXI4-Lite machine-timer peripheral: 64-bit mtime/mtimecmp and registered mtip.
// Optional CLINT_SHADOW_EN: reading mtime[31:0] snapshots mtime[63:32] for a tear-free hi read.
module ysyx_23060184_clint #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  BASE       = 32'ha000_0048,
  parameter int unsigned            DIV        = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [DATA_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mtip
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  rstate_t               rstate;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [PW-1:0]         presc;
  logic                  tick;

  logic                  aw_held, w_held;
  logic [DATA_WIDTH-1:0] aw_addr_q, w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic                  aw_fire, w_fire, commit, wr_ok;
  logic [DATA_WIDTH-1:0] wr_addr, wr_data, wr_off, ar_off;
  logic [SW-1:0]         wr_strb;
  logic [1:0]            wr_resp, rd_resp;
  logic [DATA_WIDTH-1:0] rd_word;

  // Offset is computed by subtraction so addresses below BASE wrap out of range.
  function automatic logic [1:0] decode(input logic [DATA_WIDTH-1:0] off);
    if (off[DATA_WIDTH-1:4] != '0) return RESP_DECERR;
    else if (off[1:0] != 2'b00)    return RESP_SLVERR;
    else                           return RESP_OKAY;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [SW-1:0]         s);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < int'(SW); i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  // A write commits in the cycle both halves are held or arriving.
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign commit  = (aw_held | aw_fire) & (w_held | w_fire);
  assign wr_off  = wr_addr - BASE;
  assign wr_resp = decode(wr_off);
  assign wr_ok   = commit & (wr_resp == RESP_OKAY);
  assign ar_off  = araddr - BASE;
  assign rd_resp = decode(ar_off);
  assign tick    = (presc == PW'(DIV - 1));

`ifdef CLINT_SHADOW_EN
  logic [31:0] shadow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) shadow <= '0;
    else if (rstate == R_IDLE && arvalid && rd_resp == RESP_OKAY && ar_off[3:2] == 2'd0)
      shadow <= mtime[63:32];
  end
`endif

  always_comb begin
    rd_word = '0;
    case (ar_off[3:2])
      2'd0: rd_word = mtime[31:0];
`ifdef CLINT_SHADOW_EN
      2'd1: rd_word = shadow;
`else
      2'd1: rd_word = mtime[63:32];
`endif
      2'd2: rd_word = mtimecmp[31:0];
      default: rd_word = mtimecmp[63:32];
    endcase
  end

  // Timer state; a software write to mtime takes priority over the tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      mtip  <= (mtime >= mtimecmp);
      if (wr_ok && wr_off[3:2] == 2'd0)
        mtime <= {mtime[63:32], merge(mtime[31:0], wr_data, wr_strb)};
      else if (wr_ok && wr_off[3:2] == 2'd1)
        mtime <= {merge(mtime[63:32], wr_data, wr_strb), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr_ok && wr_off[3:2] == 2'd2)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], wr_data, wr_strb);
      if (wr_ok && wr_off[3:2] == 2'd3)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], wr_data, wr_strb);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= wr_resp;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
        awready   <= 1'b0;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        wready   <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end
    end
  end

  // Read channel: one-cycle AR-to-R latency, response held until rready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          rresp   <= rd_resp;
          rdata   <= (rd_resp == RESP_OKAY) ? rd_word : '0;
          rvalid  <= 1'b1;
          arready <= 1'b0;
          rstate  <= R_RESP;
        end
        default: if (rready) begin
          rvalid  <= 1'b0;
          arready <= 1'b1;
          rstate  <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_clint.sv
// Directed bench for ysyx_23060184_clint: vector table plus hand-written timing sequences.
module tb_ysyx_23060184_clint;

  localparam logic [31:0] BASE = 32'ha000_0048;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, mtip;
  logic [3:0]  wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  // mtime model: value 'base' at cycle 'bc', +1 per cycle afterwards (DIV = 1)
  longint unsigned cyc = 0;
  logic [63:0]     base = '0;
  longint unsigned bc = 0;

  ysyx_23060184_clint dut (
    .clk(clk), .resetn(resetn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mtip(mtip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resetn) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model();
    return base + 64'(cyc - bc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is just after a negedge; returns just after a negedge.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic [63:0] mexp, output logic ok);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    mexp = model();
    ok = arready;
    @(negedge clk);
    arvalid = 1'b0;
    ok &= rvalid;
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    ok &= !rvalid;
  endtask

  // Full-word writes to mtime update the model at the commit edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic ok, output logic mtip1);
    logic [63:0] cur;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    cur = model();
    ok = awready & wready;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    ok &= bvalid;
    resp = bresp; mtip1 = mtip;
    if (bresp == 2'b00 && addr == BASE)        begin base = {cur[63:32], data}; bc = cyc; end
    if (bresp == 2'b00 && addr == BASE + 32'h4) begin base = {data, cur[31:0]}; bc = cyc; end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    ok &= !bvalid;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] m, prev;
    logic        ok, m1, trk_ok;

    vt[0]  = '{1'b0, BASE + 32'h10, 32'h0,         4'h0, 2'b11, 32'h0};
    vt[1]  = '{1'b1, BASE + 32'h2,  32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vt[2]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0, 2'b00, 32'h0000_0020};
    vt[3]  = '{1'b0, BASE + 32'h6,  32'h0,         4'h0, 2'b10, 32'h0};
    vt[4]  = '{1'b1, BASE - 32'h4,  32'h0,         4'hF, 2'b11, 32'h0};
    vt[5]  = '{1'b1, BASE + 32'h8,  32'h1234_5678, 4'h9, 2'b00, 32'h0};
    vt[6]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0, 2'b00, 32'h1200_0078};
    vt[7]  = '{1'b1, BASE + 32'hC,  32'h0,         4'h4, 2'b00, 32'h0};
    vt[8]  = '{1'b0, BASE + 32'hC,  32'h0,         4'h0, 2'b00, 32'hFF00_FFFF};
    vt[9]  = '{1'b0, BASE + 32'h20, 32'h0,         4'h0, 2'b11, 32'h0};
    vt[10] = '{1'b1, BASE + 32'hF,  32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
    vt[11] = '{1'b0, BASE + 32'hC,  32'h0,         4'h0, 2'b00, 32'hFF00_FFFF};

    resetn = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mtip", mtip, 0);
    resetn = 1'b1;
    chk("rst_readies", {arready, awready, wready}, 3'b111);

    // Idle after reset, then read mtime low word.
    repeat (10) @(negedge clk);
    do_read(BASE, d, r, m, ok);
    chk("idle_rd_handshake", ok, 1);
    chk("idle_rd_resp", r, 2'b00);
    chk("idle_rd_mtime", d, m[31:0]);
    chk("idle_rd_cycles", d, 32'd10);
    chk("idle_mtip", mtip, 0);
    do_read(BASE + 32'hC, d, r, m, ok);
    chk("rst_cmp_hi", d, 32'hFFFF_FFFF);

    // Split AW/W with a single byte strobe onto mtimecmp low.
    awaddr = BASE + 32'h8; awvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    chk("split_aw_held", {awready, wready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("split_no_early_b", bvalid, 0);
    wdata = 32'h0000_AB00; wstrb = 4'b0010; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("split_bvalid", bvalid, 1);
    chk("split_bresp", bresp, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("split_b_hold", {bvalid, awready}, 2'b10);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("split_b_done", {bvalid, awready, wready}, 3'b011);
    do_read(BASE + 32'h8, d, r, m, ok);
    chk("split_cmp_lo", d, 32'hFFFF_ABFF);

    // mtip assertion and deassertion.
    do_write(BASE, 32'h0, 4'hF, r, ok, m1);
    chk("mt_clear_ok", ok, 1);
    do_write(BASE + 32'h8, 32'h20, 4'hF, r, ok, m1);
    do_write(BASE + 32'hC, 32'h0, 4'hF, r, ok, m1);
    chk("cmp_hi_wr", {ok, r}, 3'b100);
    chk("mtip_low_start", mtip, 0);
    trk_ok = 1'b1;
    prev = model();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mtip !== (prev >= 64'h20)) begin
        if (trk_ok) $display("FAIL mtip_track: cycle %0d got %b, expected %b", i, mtip, prev >= 64'h20);
        trk_ok = 1'b0;
      end
      prev = model();
    end
    n_tests++;
    if (!trk_ok) n_fail++;
    chk("mtip_high", mtip, 1);
    do_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, r, ok, m1);
    chk("mtip_lag_commit", m1, 1);
    chk("mtip_drop", mtip, 0);

    // Decode, error and strobe vectors.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].wdata, vt[i].strb, r, ok, m1);
        chk($sformatf("vec%0d_bresp", i), {ok, r}, {1'b1, vt[i].resp});
      end else begin
        do_read(vt[i].addr, d, r, m, ok);
        chk($sformatf("vec%0d_rresp", i), {ok, r}, {1'b1, vt[i].resp});
        chk($sformatf("vec%0d_rdata", i), d, vt[i].rdata);
      end
    end

    // Carry from the low word into the high word.
    do_write(BASE + 32'h4, 32'h0, 4'hF, r, ok, m1);
    do_write(BASE, 32'hFFFF_FFFF, 4'hF, r, ok, m1);
    repeat (2) @(negedge clk);
    do_read(BASE + 32'h4, d, r, m, ok);
    chk("carry_hi", d, 32'd1);
    do_read(BASE, d, r, m, ok);
    chk("carry_lo_model", d, m[31:0]);
    chk("carry_lo_small", d < 32'd16, 1);

    // Low-then-high read across a carry.
    do_write(BASE + 32'h4, 32'h1, 4'hF, r, ok, m1);
    do_write(BASE, 32'hFFFF_FFF0, 4'hF, r, ok, m1);
    do_read(BASE, d, r, m, ok);
    chk("shadow_lo", d, m[31:0]);
    repeat (40) @(negedge clk);
    do_read(BASE + 32'h4, d, r, m, ok);
`ifdef CLINT_SHADOW_EN
    chk("shadow_hi", d, 32'd1);
`else
    chk("shadow_hi", d, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_clint.md
Name: ysyx_23060184_clint

Overview:
- Memory-mapped machine-timer peripheral: a 64-bit free-running mtime, a 64-bit mtimecmp, and a timer-interrupt level output.
- AXI4-Lite slave sitting downstream of the data-memory master port, beside SRAM and UART. It is reached through the same arbitrated d_* channel.
- Software reads time and programs compare values through word-sized reads and writes.

Parameters:
- DATA_WIDTH, 32, AXI data and address width.
- BASE, 32'ha000_0048, byte address of the 16-byte register window.
- DIV, 1, clk cycles per mtime increment; must be >= 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte write strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response, same encoding as rresp
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- mtip  out  1  timer interrupt pending, registered

Behaviour:
- Reset state:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; prescaler = 0.
  - rvalid = bvalid = 0; rdata = 0; rresp = bresp = 00; mtip = 0.
  - arready = awready = wready = 1 once resetn is high.
  - Reset mid-transaction aborts it with no response.
- Register map, word offsets from BASE:
  - 0x0: mtime[31:0]
  - 0x4: mtime[63:32]
  - 0x8: mtimecmp[31:0]
  - 0xC: mtimecmp[63:32]
- Address decode:
  - Address outside BASE..BASE+15: DECERR.
  - addr[1:0] != 0: SLVERR.
  - Error reads return rdata = 0; error writes modify nothing.
- Counter:
  - Prescaler counts 0..DIV-1. At DIV-1 it returns to 0 and mtime increments by 1.
  - mtime is a 64-bit add that wraps from all-ones to 0.
- mtip register: next value = (mtime >= mtimecmp), unsigned, evaluated on current register values. This gives one cycle of lag after any change.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready = 1. arvalid high -> decode, latch rdata/rresp, go to R_RESP. Latency is 1 cycle from the AR handshake to rvalid.
  - R_RESP: arready = 0, rvalid = 1. rdata/rresp are stable until rready; rready high -> R_IDLE.
  - Back-to-back reads therefore take 2 cycles minimum.
- Write FSM:
  - Address and data are captured independently.
  - awready = 1 while no address is held and bvalid = 0. wready = 1 while no data is held and bvalid = 0.
  - In the cycle both are held, commit the write with wstrb byte-lane masking. Next cycle bvalid = 1 and both holding flags clear.
  - bvalid is held until bready.
- Simultaneous events:
  - A CPU write to mtime beats the same-cycle increment. The written value lands exactly; the prescaler is not reset.
  - A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
  - A write to mtimecmp is visible on mtip on the second cycle after commit.

Optional Feature:
- Macro: CLINT_SHADOW_EN.
- Defined:
  - A read of offset 0x0 also copies the live mtime[63:32] into a 32-bit shadow register.
  - A read of offset 0x4 returns the shadow, giving a tear-free lo-then-hi 64-bit read.
  - The shadow resets to 0.
- Undefined: offset 0x4 returns live mtime[63:32]; no shadow register is built.

Test Plan:
- Reset, DIV = 1, idle 10 cycles, read 0x0:
  - Expect rvalid exactly 1 cycle after the AR handshake, rresp = 00, and rdata equal to the cycle count since reset release (within +-1 per bench model).
  - Expect mtip = 0 throughout.
- Counter carry across the word boundary:
  - Write 0xFFFF_FFFF to 0x0 and 0x0 to 0x4, wait 2 cycles.
  - Read 0x4 -> rdata = 1. Read 0x0 -> small value (wrap carried into the upper word).
- mtip assertion:
  - Write 0x8 = 0x20, then 0xC = 0; mtime starts below 0x20.
  - mtip rises on the second cycle after mtime reaches 0x20.
  - Writing 0xC = 0xFFFF_FFFF drops mtip 2 cycles after commit.
- Split AW/W with byte strobes:
  - AW at cycle 0, W at cycle 3, wstrb = 4'b0010, wdata = 0x0000_AB00 to 0x8 (mtimecmp reset value).
  - Expect bvalid at cycle 4, bresp = 00, mtimecmp[31:0] = 0xFFFF_ABFF.
  - Hold bready low 3 cycles: bvalid stays 1 and awready = 0.
- Error responses:
  - Read BASE+0x10 -> rresp = 11, rdata = 0.
  - Write BASE+0x2 -> bresp = 10, no register change.
  - Read-back of mtimecmp is unchanged.
- CLINT_SHADOW_EN:
  - Set mtime = 0x0000_0001_FFFF_FFF0, read 0x0, wait 40 cycles, read 0x4.
  - Defined: 0x4 returns 1. Undefined: 0x4 returns 2.
